// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Shared constants for the single-cycle execute datapath:
//               ALU operation codes, default widths and instruction field
//               bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    // Default geometry
    localparam int DATA_W    = 32;
    localparam int NREGS     = 32;
    localparam int MEM_WORDS = 64;

    // ALU operation encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Instruction field positions
    localparam int REG_AW  = 5;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

endpackage : datapath_pkg
`default_nettype wire

// File: rtl/datapath_regfile.sv
`default_nettype none
// ============================================================================
// Module      : datapath_regfile
// Description : Two-read / one-write register file. Entry 0 is hardwired to
//               zero on read and never written. Synchronous clear on rst.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_rd_addr_a,
    input  logic [ADDR_W-1:0] i_rd_addr_b,
    output logic [DATA_W-1:0] o_rd_data_a,
    output logic [DATA_W-1:0] o_rd_data_b,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);

    localparam int c_NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [c_NREGS];

    // Asynchronous reads; register 0 always reads as zero
    assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_regs[i_rd_addr_a];
    assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_regs[i_rd_addr_b];

    // Clear all entries on reset, otherwise commit an enabled write to a nonzero entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

endmodule : datapath_regfile
`default_nettype wire

// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
// Module      : datapath
// Description : Single-cycle MIPS-style execute datapath: register file,
//               sign extender, ALU, data memory and write-back mux. Control
//               is decoded externally; branch/jump decisions live upstream.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath #(
    parameter int DATA_W    = 32,
    parameter int NREGS     = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegDst,
    input  logic              RegWr,
    input  logic              ALUsrc,
    input  logic [1:0]        ALUcntrl,
    input  logic              MemWr,
    input  logic              MemToReg,
    input  logic [31:0]       Instructions,
    output logic              Zero,
    output logic [DATA_W-1:0] seOut,
    output logic [DATA_W-1:0] reg_Da
);

    import datapath_pkg::*;

    localparam int c_REG_AW = $clog2(NREGS);
    localparam int c_MEM_AW = $clog2(MEM_WORDS);

    logic [c_REG_AW-1:0] w_rs;
    logic [c_REG_AW-1:0] w_rt;
    logic [c_REG_AW-1:0] w_rd;
    logic [c_REG_AW-1:0] w_wr_addr;
    logic [DATA_W-1:0]   w_reg_db;
    logic [DATA_W-1:0]   w_alu_b;
    logic [DATA_W-1:0]   w_alu_result;
    logic [DATA_W-1:0]   w_mem_rdata;
    logic [DATA_W-1:0]   w_wr_data;
    logic [c_MEM_AW-1:0] w_mem_idx;
    logic [DATA_W-1:0]   r_mem [MEM_WORDS];

    // Instruction field extraction
    assign w_rs = Instructions[RS_MSB:RS_LSB];
    assign w_rt = Instructions[RT_MSB:RT_LSB];
    assign w_rd = Instructions[RD_MSB:RD_LSB];

    // Sign-extended immediate, also exported to the fetch unit
    assign seOut = {{(DATA_W-IMM_W){Instructions[IMM_MSB]}}, Instructions[IMM_MSB:IMM_LSB]};

    datapath_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (c_REG_AW)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_rd_addr_a (w_rs),
        .i_rd_addr_b (w_rt),
        .o_rd_data_a (reg_Da),
        .o_rd_data_b (w_reg_db),
        .i_wr_en     (RegWr),
        .i_wr_addr   (w_wr_addr),
        .i_wr_data   (w_wr_data)
    );

    assign w_alu_b = ALUsrc ? seOut : w_reg_db;

    // Wrap-around ALU; no overflow detection
    always_comb begin
        w_alu_result = '0;
        case (ALUcntrl)
            ALU_ADD: w_alu_result = reg_Da + w_alu_b;
            ALU_SUB: w_alu_result = reg_Da - w_alu_b;
            ALU_AND: w_alu_result = reg_Da & w_alu_b;
            ALU_OR:  w_alu_result = reg_Da | w_alu_b;
            default: w_alu_result = '0;
        endcase
    end

    assign Zero = (w_alu_result == '0);

    // Word index into data memory; byte offset and high address bits are dropped
    assign w_mem_idx   = w_alu_result[c_MEM_AW+1:2];
    assign w_mem_rdata = r_mem[w_mem_idx];

    // Clear data memory on reset, otherwise store rt data when enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (MemWr) begin
            r_mem[w_mem_idx] <= w_reg_db;
        end
    end

    // Write-back selection
    assign w_wr_addr = RegDst ? w_rd : w_rt;
    assign w_wr_data = MemToReg ? w_mem_rdata : w_alu_result;

    // Opcode and the address bits outside the memory window are intentionally unused
    logic w_unused;
    assign w_unused = &{1'b0, Instructions[31:26], w_alu_result[DATA_W-1:c_MEM_AW+2],
                        w_alu_result[1:0]};

endmodule : datapath
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath
// Description : Self-checking bench for datapath: directed program plus
//               randomized instructions against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath;

    logic        clk;
    logic        rst;
    logic        RegDst;
    logic        RegWr;
    logic        ALUsrc;
    logic [1:0]  ALUcntrl;
    logic        MemWr;
    logic        MemToReg;
    logic [31:0] Instructions;
    logic        Zero;
    logic [31:0] seOut;
    logic [31:0] reg_Da;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_reg [32];
    logic [31:0] m_mem [64];

    datapath #(
        .DATA_W    (32),
        .NREGS     (32),
        .MEM_WORDS (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .RegDst       (RegDst),
        .RegWr        (RegWr),
        .ALUsrc       (ALUsrc),
        .ALUcntrl     (ALUcntrl),
        .MemWr        (MemWr),
        .MemToReg     (MemToReg),
        .Instructions (Instructions),
        .Zero         (Zero),
        .seOut        (seOut),
        .reg_Da       (reg_Da)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
        return {6'd0, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 11'd0};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
    endtask

    // One instruction cycle: drive, check combinational outputs, clock, update model
    task automatic step(input logic r, input logic regdst, input logic regwr,
                        input logic alusrc, input logic [1:0] op, input logic memwr,
                        input logic memtoreg, input logic [31:0] instr, input string tag);
        logic [31:0] se, a, b_reg, b, y, rdata;
        int rs, rt, rd, idx;
        rst = r; RegDst = regdst; RegWr = regwr; ALUsrc = alusrc;
        ALUcntrl = op; MemWr = memwr; MemToReg = memtoreg; Instructions = instr;
        #2;
        rs = int'(instr[25:21]);
        rt = int'(instr[20:16]);
        rd = int'(instr[15:11]);
        se = {{16{instr[15]}}, instr[15:0]};
        a = m_reg[rs];
        b_reg = m_reg[rt];
        b = alusrc ? se : b_reg;
        case (op)
            2'd0: y = a + b;
            2'd1: y = a - b;
            2'd2: y = a & b;
            default: y = a | b;
        endcase
        idx = int'((y % 256) / 4);
        rdata = m_mem[idx];
        chk({tag, "_seOut"}, seOut, se);
        chk({tag, "_reg_Da"}, reg_Da, a);
        chk({tag, "_Zero"}, {31'd0, Zero}, {31'd0, (y == 0)});
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            if (regwr === 1'b1) begin
                if ((regdst ? rd : rt) != 0) m_reg[regdst ? rd : rt] = memtoreg ? rdata : y;
            end
            if (memwr === 1'b1) m_mem[idx] = b_reg;
        end
        #1;
    endtask

    task automatic read_reg(input logic [4:0] n, input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, ins(n, 5'd0, 16'd0), tag);
    endtask

    initial begin
        rst = 1'b1; RegDst = 1'b0; RegWr = 1'b0; ALUsrc = 1'b0; ALUcntrl = 2'b00;
        MemWr = 1'b0; MemToReg = 1'b0; Instructions = '0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst = 1'b0;

        // Every register reads zero after reset
        for (int n = 1; n < 32; n++) begin
            read_reg(5'(n), "rst_reg");
            chk("rst_reg_const", reg_Da, 32'd0);
        end

        // lw $3,0($0) from cleared memory
        step(0, 0, 1, 1, 2'b00, 0, 1, ins(5'd0, 5'd3, 16'd0), "lw_rst");
        read_reg(5'd3, "rd3_rst");
        chk("mem0_rst", reg_Da, 32'd0);

        // addi $1,$0,2015 ; addi $2,$0,404
        step(0, 0, 1, 1, 2'b00, 0, 0, ins(5'd0, 5'd1, 16'd2015), "addi1");
        chk("se_2015", seOut, 32'd2015);
        step(0, 0, 1, 1, 2'b00, 0, 0, ins(5'd0, 5'd2, 16'd404), "addi2");
        chk("se_404", seOut, 32'd404);
        read_reg(5'd1, "rd1");
        chk("r1_2015", reg_Da, 32'd2015);
        read_reg(5'd2, "rd2");
        chk("r2_404", reg_Da, 32'd404);

        // add $1,$1,$2
        step(0, 1, 1, 0, 2'b00, 0, 0, rtype(5'd1, 5'd2, 5'd1), "add");
        read_reg(5'd1, "rd1b");
        chk("r1_2419", reg_Da, 32'd2419);

        // sw $2,0($0) with don't-care write-back controls
        step(0, 1'bx, 0, 1, 2'b00, 1, 1'bx, ins(5'd0, 5'd2, 16'd0), "sw");
        read_reg(5'd1, "rd1c");
        chk("r1_after_sw", reg_Da, 32'd2419);
        // lw $3,0($0)
        step(0, 0, 1, 1, 2'b00, 0, 1, ins(5'd0, 5'd3, 16'd0), "lw");
        read_reg(5'd3, "rd3");
        chk("r3_404", reg_Da, 32'd404);

        // addi $4,$0,-1
        step(0, 0, 1, 1, 2'b00, 0, 0, ins(5'd0, 5'd4, 16'hFFFF), "addim1");
        chk("se_ffff", seOut, 32'hFFFF_FFFF);
        read_reg(5'd4, "rd4");
        chk("r4_m1", reg_Da, 32'hFFFF_FFFF);

        // add $7,$4,$6 with $6=1 wraps to zero
        step(0, 0, 1, 1, 2'b00, 0, 0, ins(5'd0, 5'd6, 16'd1), "addi6");
        step(0, 1, 1, 0, 2'b00, 0, 0, rtype(5'd4, 5'd6, 5'd7), "addwrap");
        chk("wrap_zero", {31'd0, Zero}, 32'd1);
        read_reg(5'd7, "rd7");
        chk("r7_zero", reg_Da, 32'd0);

        // sub $5,$2,$2 ; sub $1,$2 (no write)
        step(0, 1, 1, 0, 2'b01, 0, 0, rtype(5'd2, 5'd2, 5'd5), "sub22");
        chk("sub_zero", {31'd0, Zero}, 32'd1);
        read_reg(5'd5, "rd5");
        chk("r5_zero", reg_Da, 32'd0);
        step(0, 0, 0, 0, 2'b01, 0, 0, rtype(5'd1, 5'd2, 5'd0), "sub12");
        chk("sub_nonzero", {31'd0, Zero}, 32'd0);

        // Write to $0 is discarded
        step(0, 0, 1, 1, 2'b00, 0, 0, ins(5'd0, 5'd0, 16'd5), "wr0");
        read_reg(5'd0, "rd0");
        chk("r0_zero", reg_Da, 32'd0);

        // Randomized instructions against the model
        for (int k = 0; k < 400; k++) begin
            logic [31:0] rin;
            rin = $urandom;
            if ($urandom_range(0, 3) == 0) rin[25:21] = 5'd0;
            step(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 2'($urandom), 1'($urandom), 1'($urandom), rin, "rand");
        end

        // Populate some state, then reset with writes asserted
        step(0, 0, 1, 1, 2'b00, 0, 0, ins(5'd0, 5'd9, 16'h1234), "pre_rst");
        step(0, 0, 0, 1, 2'b00, 1, 0, ins(5'd0, 5'd9, 16'd8), "pre_rst_sw");
        step(1, 0, 1, 1, 2'b00, 1, 0, ins(5'd0, 5'd8, 16'd7), "mid_rst");
        for (int n = 1; n < 32; n++) begin
            read_reg(5'(n), "mrst_reg");
            chk("mrst_reg_const", reg_Da, 32'd0);
        end
        for (int w = 0; w < 64; w++) begin
            step(0, 0, 1, 1, 2'b00, 0, 1, ins(5'd0, 5'd1, 16'(w * 4)), "mrst_lw");
            read_reg(5'd1, "mrst_mem");
            chk("mrst_mem_const", reg_Da, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_datapath
`default_nettype wire
